jk_pattern_machine: RTL and testbench
=====================================

Name: jk_pattern_machine

Overview:
- Parametrised successor to the fixed 3-bit JK-flip-flop state machines in this lab set.
- Serial-input pattern detector whose state register is built entirely from JK flip-flops, each driven as J=d, K=~d.
- Adds run-time loadable pattern, enable, overlap/non-overlap mode and a saturating match counter.
- Sits between a serial bit source and the lab's display/checker logic; exposes state S and registered match flag F.

Parameters:
- N, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the match counter.
- PATTERN_INIT, 4'b1011 (N bits), pattern register value after reset.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit, sampled on the rising edge when en=1.
- en  input  1  shift enable.
- load  input  1  load pattern and restart; has priority over en.
- pattern  input  N  new pattern, captured when load=1.
- overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- F  output  1  registered one-cycle match pulse.
- S  output  N  current history register H; newest bit in LSB.
- count  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset (async, immediate, no clock needed):
  - H=0, fill=0, pattern_reg=PATTERN_INIT, F=0, count=0.
  - Reset asserted mid-stream discards all history.
- Internal state:
  - H[N-1:0]: history register.
  - fill: 0..N, number of valid bits in H; width $clog2(N+1).
  - pattern_reg[N-1:0].
  - All of these are held in JK flip-flops.
- Edge with load=1:
  - pattern_reg<=pattern, H<=0, fill<=0, F<=0; count unchanged; x ignored.
- Edge with load=0, en=0:
  - H, fill, pattern_reg and count hold; F<=0.
- Edge with load=0, en=1:
  - H_nxt={H[N-2:0],x}; fill_inc=min(fill+1,N).
  - match = (fill_inc==N) && (H_nxt==pattern_reg).
  - H<=H_nxt; F<=match.
  - fill <= (match && !overlap) ? 0 : fill_inc.
  - If match: count<=count+1, holding at 2^CNT_W-1 (no wrap).
- Latency and pulse width:
  - F rises in the cycle immediately after the edge that samples the completing bit.
  - F is high for exactly one cycle per match.
  - Back-to-back matches in overlap mode give F high on consecutive cycles.
- Mode timing:
  - overlap is sampled at each edge; a change applies to the match decision at that same edge.
  - A preceding non-overlap reset of fill is not undone by a later change to overlap.
- Boundaries:
  - No match is possible before N valid bits have been shifted since reset, load or a non-overlap match.
  - load and en both high: load wins.
  - Changing pattern while load=0 has no effect.

Decomposition:
- Package jk_pm_pkg holds:
  - default N, CNT_W and PATTERN_INIT;
  - a function fill_width(N) = $clog2(N+1).
- One sub-module, jk_reg:
  - WIDTH-bit register of the team's jkff cells with async active-high reset;
  - ports CLK, RESET, d[WIDTH-1:0] (J=d, K=~d internally), q.
  - The reset value is set by a parameter and realised as a post-reset load, or via per-bit set/clear variants of jkff.
- The top level instantiates jk_reg for H, fill, pattern_reg, F and count.
- Next-state logic is combinational in the top level.

Test Plan:
- Reset: pulse RESET with no clock -> F=0, S=0000, count=0 immediately; first match checks against 1011.
- Overlap: overlap=1, en=1, x=1,0,1,1,0,1,1 -> F high after bit 4 and after bit 7; count=2; S=1011 after bit 7.
- Non-overlap: overlap=0, same stream -> F high after bit 4 only; count=1; fill back to 3 after bit 7.
- Enable gaps: stream 1,0 then en=0 for 3 cycles, then 1,1 -> S holds 0010 during the gap, F=0 throughout the gap, F pulses once after the final 1.
- Load mid-stream:
  - after bits 1,0, assert load with pattern=0000 -> S=0000, fill=0;
  - then x=0 for 5 edges with overlap=1 -> F high after edges 4 and 5;
  - load+en together -> load wins, no shift.
- Saturation and async reset:
  - CNT_W=2, five overlap matches (x=1 stream, pattern 1111) -> count stays 3;
  - assert RESET mid-stream between edges -> count, S and F clear to 0 asynchronously.

Source files
------------

// File: rtl/jk_pm_pkg.sv
// jk_pattern_machine shared definitions
// default geometry and fill-counter sizing
package jk_pm_pkg;

  localparam int          DEF_N       = 4;
  localparam int          DEF_CNT_W   = 8;
  localparam logic [15:0] DEF_PATTERN = 16'h000B;

  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jk_reg.sv
// jk_reg: bank of JK flip-flops, J=d K=~d
// async active-high reset to RST_VAL per bit
module jk_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  assign j = d;
  assign k = ~d;

  // per-bit JK behaviour; reset picks set or clear variant
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q <= RST_VAL;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({j[i], k[i]})
          2'b10:   q[i] <= 1'b1;
          2'b01:   q[i] <= 1'b0;
          2'b11:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/jk_pattern_machine.sv
// jk_pattern_machine: serial pattern detector
// all state in jk_reg banks; next state here
module jk_pattern_machine
  import jk_pm_pkg::*;
#(
  parameter int           N            = DEF_N,
  parameter int           CNT_W        = DEF_CNT_W,
  parameter logic [N-1:0] PATTERN_INIT = DEF_PATTERN[N-1:0]
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             x,
  input  logic             en,
  input  logic             load,
  input  logic [N-1:0]     pattern,
  input  logic             overlap,
  output logic             F,
  output logic [N-1:0]     S,
  output logic [CNT_W-1:0] count
);

  localparam int                FW   = fill_width(N);
  localparam logic [FW-1:0]     NF   = FW'(N);
  localparam logic [CNT_W-1:0]  CMAX = '1;

  logic [N-1:0]     h_q, h_d, h_nxt;
  logic [FW-1:0]    fill_q, fill_d, fill_inc;
  logic [N-1:0]     pat_q, pat_d;
  logic             f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match;

  jk_reg #(.WIDTH(N), .RST_VAL('0)) u_h (
    .CLK(CLK), .RESET(RESET), .d(h_d), .q(h_q)
  );

  jk_reg #(.WIDTH(FW), .RST_VAL('0)) u_fill (
    .CLK(CLK), .RESET(RESET), .d(fill_d), .q(fill_q)
  );

  jk_reg #(.WIDTH(N), .RST_VAL(PATTERN_INIT)) u_pat (
    .CLK(CLK), .RESET(RESET), .d(pat_d), .q(pat_q)
  );

  jk_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_f (
    .CLK(CLK), .RESET(RESET), .d(f_d), .q(f_q)
  );

  jk_reg #(.WIDTH(CNT_W), .RST_VAL('0)) u_cnt (
    .CLK(CLK), .RESET(RESET), .d(cnt_d), .q(cnt_q)
  );

  // load beats shift; fill saturates at N; count saturates
  always_comb begin
    h_d      = h_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    f_d      = 1'b0;
    cnt_d    = cnt_q;
    h_nxt    = {h_q[N-2:0], x};
    fill_inc = (fill_q == NF) ? NF : fill_q + FW'(1);
    match    = (fill_inc == NF) && (h_nxt == pat_q);
    if (load) begin
      pat_d  = pattern;
      h_d    = '0;
      fill_d = '0;
    end else if (en) begin
      h_d    = h_nxt;
      f_d    = match;
      fill_d = (match && !overlap) ? '0 : fill_inc;
      if (match && cnt_q != CMAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign F     = f_q;
  assign S     = h_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_jk_pattern_machine.sv
// tb_jk_pattern_machine: directed vector bench
// main instance N=4/CNT_W=8, second CNT_W=2
module tb_jk_pattern_machine;

  logic       CLK;
  logic       RESET;
  logic       x, en, load, overlap;
  logic [3:0] pattern;
  logic       F;
  logic [3:0] S;
  logic [7:0] count;

  logic       x2, en2, load2, ov2;
  logic [3:0] pat2;
  logic       F2;
  logic [3:0] S2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       x;
    logic       en;
    logic       load;
    logic [3:0] pat;
    logic       ov;
    logic       ef;
    logic [3:0] es;
    logic [2:0] efill;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  jk_pattern_machine #(.N(4), .CNT_W(8), .PATTERN_INIT(4'b1011)) dut (
    .CLK(CLK), .RESET(RESET), .x(x), .en(en), .load(load),
    .pattern(pattern), .overlap(overlap),
    .F(F), .S(S), .count(count)
  );

  jk_pattern_machine #(.N(4), .CNT_W(2), .PATTERN_INIT(4'b1011)) dut2 (
    .CLK(CLK), .RESET(RESET), .x(x2), .en(en2), .load(load2),
    .pattern(pat2), .overlap(ov2),
    .F(F2), .S(S2), .count(cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic vx, input logic ven, input logic vld,
                     input logic [3:0] vpat, input logic vov,
                     input logic ef, input logic [3:0] es,
                     input logic [2:0] efl, input logic [7:0] ec);
    vec_t v;
    v.x = vx; v.en = ven; v.load = vld; v.pat = vpat; v.ov = vov;
    v.ef = ef; v.es = es; v.efill = efl; v.ecnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    RESET = 1'b0;
    x = 0; en = 0; load = 0; overlap = 0; pattern = 4'b1011;
    x2 = 0; en2 = 0; load2 = 0; ov2 = 0; pat2 = 4'b0000;

    // overlap stream 1011011
    add(1,1,0,4'b1011,1, 0,4'b0001,1,0);
    add(0,1,0,4'b1011,1, 0,4'b0010,2,0);
    add(1,1,0,4'b1011,1, 0,4'b0101,3,0);
    add(1,1,0,4'b1011,1, 1,4'b1011,4,1);
    add(0,1,0,4'b1011,1, 0,4'b0110,4,1);
    add(1,1,0,4'b1011,1, 0,4'b1101,4,1);
    add(1,1,0,4'b1011,1, 1,4'b1011,4,2);
    // restart, non-overlap stream
    add(1,0,1,4'b1011,0, 0,4'b0000,0,2);
    add(1,1,0,4'b1011,0, 0,4'b0001,1,2);
    add(0,1,0,4'b1011,0, 0,4'b0010,2,2);
    add(1,1,0,4'b1011,0, 0,4'b0101,3,2);
    add(1,1,0,4'b1011,0, 1,4'b1011,0,3);
    add(0,1,0,4'b1011,0, 0,4'b0110,1,3);
    add(1,1,0,4'b1011,0, 0,4'b1101,2,3);
    add(1,1,0,4'b1011,0, 0,4'b1011,3,3);
    // enable gaps
    add(1,0,1,4'b1011,1, 0,4'b0000,0,3);
    add(1,1,0,4'b1011,1, 0,4'b0001,1,3);
    add(0,1,0,4'b1011,1, 0,4'b0010,2,3);
    add(1,0,0,4'b1011,1, 0,4'b0010,2,3);
    add(1,0,0,4'b1011,1, 0,4'b0010,2,3);
    add(0,0,0,4'b1011,1, 0,4'b0010,2,3);
    add(1,1,0,4'b1011,1, 0,4'b0101,3,3);
    add(1,1,0,4'b1011,1, 1,4'b1011,4,4);
    add(1,0,0,4'b1011,1, 0,4'b1011,4,4);
    // load 0000 mid-stream, zeros
    add(1,0,1,4'b0000,1, 0,4'b0000,0,4);
    add(0,1,0,4'b0000,1, 0,4'b0000,1,4);
    add(0,1,0,4'b0000,1, 0,4'b0000,2,4);
    add(0,1,0,4'b0000,1, 0,4'b0000,3,4);
    add(0,1,0,4'b0000,1, 1,4'b0000,4,5);
    add(0,1,0,4'b0000,1, 1,4'b0000,4,6);
    // load+en: load wins
    add(1,1,1,4'b1011,1, 0,4'b0000,0,6);
    // pattern input changes without load: ignored
    add(1,1,0,4'b0000,1, 0,4'b0001,1,6);
    add(0,1,0,4'b0000,1, 0,4'b0010,2,6);
    add(1,1,0,4'b0000,1, 0,4'b0101,3,6);
    add(1,1,0,4'b0000,1, 1,4'b1011,4,7);
    // overlap change applies at same edge
    add(0,1,0,4'b0000,0, 0,4'b0110,4,7);
    add(1,1,0,4'b0000,0, 0,4'b1101,4,7);
    add(1,1,0,4'b0000,0, 1,4'b1011,0,8);
    add(0,1,0,4'b0000,1, 0,4'b0110,1,8);

    // async reset with no clock edge
    #2 RESET = 1'b1;
    #1;
    chk("rst_F", 0, F, 1'b0);
    chk("rst_S", 0, S, 4'b0000);
    chk("rst_cnt", 0, count, 8'd0);
    chk("rst_fill", 0, dut.fill_q, 3'd0);
    @(negedge CLK);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      x = vecs[i].x; en = vecs[i].en; load = vecs[i].load;
      pattern = vecs[i].pat; overlap = vecs[i].ov;
      @(posedge CLK);
      #1;
      chk("vec_F", i, F, vecs[i].ef);
      chk("vec_S", i, S, vecs[i].es);
      chk("vec_fill", i, dut.fill_q, vecs[i].efill);
      chk("vec_cnt", i, count, vecs[i].ecnt);
    end

    // async reset mid-stream, between edges
    en = 1'b1; x = 1'b1;
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_F", 0, F, 1'b0);
    chk("mid_rst_S", 0, S, 4'b0000);
    chk("mid_rst_cnt", 0, count, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;
    en = 1'b0;

    // saturation on the 2-bit counter instance
    load2 = 1'b1; pat2 = 4'b1111;
    @(posedge CLK);
    #1;
    chk("sat_load_cnt", 0, cnt2, 2'd0);
    load2 = 1'b0; en2 = 1'b1; ov2 = 1'b1; x2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #1;
      chk("sat_F", k, F2, (k >= 4) ? 1'b1 : 1'b0);
      chk("sat_cnt", k, cnt2, (k < 4) ? 2'd0 : (k - 3 > 3) ? 2'd3 : 2'(k - 3));
    end

    #2 RESET = 1'b1;
    #1;
    chk("sat_rst_F", 0, F2, 1'b0);
    chk("sat_rst_S", 0, S2, 4'b0000);
    chk("sat_rst_cnt", 0, cnt2, 2'd0);
    @(posedge CLK);
    #1;
    chk("sat_hold_cnt", 0, cnt2, 2'd0);
    chk("sat_hold_S", 0, S2, 4'b0000);
    RESET = 1'b0;
    en2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
